// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the next-PC sequencer.
//   pc_state_t   - sequencer FSM state (BOOT, FETCH, TRAP)
//   INSTR_BYTES  - byte size of one instruction (sequential PC step)
//   is_misaligned - true when a control-flow target is not word aligned
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } pc_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_target_mux.sv
// pc_target_mux: priority select of the next fetch target plus the
// misalignment flag for redirect targets.
//   i_trap_ret, i_jump, i_branch_taken in  redirect requests (priority order)
//   i_epc, i_jump_target, i_branch_target, i_pc in  candidate sources
//   o_target     out selected target
//   o_misaligned out selected target is a redirect with [1:0] != 0
module pc_target_mux
  import pc_seq_pkg::*;
(
  input  logic        i_trap_ret,
  input  logic        i_jump,
  input  logic        i_branch_taken,
  input  logic [31:0] i_epc,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_pc,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic w_redirect;

  always_comb begin
    o_target   = i_pc + INSTR_BYTES;
    w_redirect = 1'b1;
    if (i_trap_ret)          o_target = i_epc + INSTR_BYTES;
    else if (i_jump)         o_target = i_jump_target & ~32'd1; // JALR clears bit 0
    else if (i_branch_taken) o_target = i_branch_target;
    else                     w_redirect = 1'b0;
  end

  // Sequential PC+4 can never be misaligned, so only redirects are checked.
  assign o_misaligned = w_redirect && is_misaligned(o_target);

endmodule

// File: rtl/program_counter.sv
// program_counter: the architectural PC register. Loads i_pc_next on
// every rising edge; the sequencer holds the PC by presenting the
// current value.
//   clk       in  clock
//   rst       in  async active-high reset, loads RESET_VALUE
//   i_pc_next in  value taken at the next edge
//   o_pc      out registered PC
module program_counter #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc_next,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= RESET_VALUE;
    else     r_pc <= i_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the RV32I fetch port.
//   clk, rst        in  clock, async active-high reset
//   stall           in  pipeline hold (overrides imem_ready)
//   imem_req        out fetch request for PC (FETCH state)
//   imem_ready      in  instruction word at PC returned this cycle
//   branch_taken/branch_target, jump/jump_target, trap_ret in  redirects
//   PC              out registered fetch address
//   PCNext          out value PC takes at the next edge
//   fetch_valid     out instruction at PC retires this cycle
//   trap            out one-cycle trap-entry pulse
//   epc             out saved PC of the faulting instruction
//   dbg_state       out current FSM state
// Handshake: an instruction retires (fetch_valid) on a cycle where the
// sequencer is in FETCH, imem_ready is high and stall is low; redirect
// inputs are only looked at on such a cycle.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap_ret,
  output logic [31:0] PC,
  output logic [31:0] PCNext,
  output logic        fetch_valid,
  output logic        trap,
  output logic [31:0] epc,
  output pc_state_t   dbg_state
);

  pc_state_t   r_state;
  pc_state_t   w_state_next;
  logic [31:0] r_epc;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic        w_advance;
  logic        w_fault;

  pc_target_mux u_mux (
    .i_trap_ret      (trap_ret),
    .i_jump          (jump),
    .i_branch_taken  (branch_taken),
    .i_epc           (r_epc),
    .i_jump_target   (jump_target),
    .i_branch_target (branch_target),
    .i_pc            (PC),
    .o_target        (w_target),
    .o_misaligned    (w_misaligned)
  );

  program_counter #(.RESET_VALUE(RESET_VECTOR)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .i_pc_next (PCNext),
    .o_pc      (PC)
  );

  assign w_advance = (r_state == FETCH) && imem_ready && !stall;
  assign w_fault   = w_advance && w_misaligned;

  // A faulting instruction holds PC; TRAP_VECTOR is loaded on leaving TRAP.
  always_comb begin
    PCNext = PC;
    if (r_state == TRAP)          PCNext = TRAP_VECTOR;
    else if (w_advance && !w_fault) PCNext = w_target;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:    w_state_next = FETCH;
      FETCH:   if (w_fault) w_state_next = TRAP;
      TRAP:    w_state_next = FETCH;
      default: w_state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
      r_epc   <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_fault) r_epc <= PC;
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign trap        = (r_state == TRAP);
  assign fetch_valid = w_advance;
  assign epc         = r_epc;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall, imem_ready, branch_taken, jump, trap_ret;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, fetch_valid, trap;
  logic [31:0] PC, PCNext, epc;
  pc_state_t   dbg_state;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_req(imem_req),
    .imem_ready(imem_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .trap_ret(trap_ret), .PC(PC), .PCNext(PCNext), .fetch_valid(fetch_valid),
    .trap(trap), .epc(epc), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Phase: 0 = waiting after reset, 1 = fetching, 2 = trap entry.
  int          m_phase;
  logic [31:0] m_pc, m_epc;
  logic [31:0] e_next;
  logic        e_valid, e_req, e_trap, e_fault;
  logic [31:0] exp_q[$];

  function automatic void model_reset();
    m_phase = 0; m_pc = RV; m_epc = 32'h0;
  endfunction

  function automatic void model_eval();
    logic [31:0] tgt;
    logic        redir;
    e_valid = (m_phase == 1) && imem_ready && !stall;
    redir   = 1'b1;
    if (trap_ret)          tgt = m_epc + 32'd4;
    else if (jump)         tgt = {jump_target[31:1], 1'b0};
    else if (branch_taken) tgt = branch_target;
    else begin tgt = m_pc + 32'd4; redir = 1'b0; end
    e_fault = e_valid && redir && (tgt % 4 != 0);
    e_req   = (m_phase == 1);
    e_trap  = (m_phase == 2);
    if (rst)                        e_next = m_pc;
    else if (m_phase == 2)          e_next = TV;
    else if (e_valid && !e_fault)   e_next = tgt;
    else                            e_next = m_pc;
  endfunction

  function automatic void model_commit();
    if (rst) begin model_reset(); return; end
    if (e_fault) begin m_epc = m_pc; m_phase = 2; end
    else m_phase = 1;
    m_pc = e_next;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic st, input logic rdy, input logic br,
                       input logic [31:0] bt, input logic jp,
                       input logic [31:0] jt, input logic tr);
    stall = st; imem_ready = rdy; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt; trap_ret = tr;
    #1;
    model_eval();
  endtask

  task automatic idle(input logic rdy);
    apply(1'b0, rdy, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    idle(1'b1);
    checks++; if (PC !== RV) begin errors++; $display("FAIL reset_pc got=%h exp=%h", PC, RV); end
    checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || trap !== 1'b0)
      begin errors++; $display("FAIL reset_ctl got=%b%b%b exp=000", imem_req, fetch_valid, trap); end
    checks++; if (PCNext !== PC || epc !== 32'h0)
      begin errors++; $display("FAIL reset_next_epc got=%h/%h exp=%h/0", PCNext, epc, PC); end
    rst = 1'b0;
    idle(1'b1);
    // BOOT cycle
    checks++; if (imem_req !== 1'b0 || PCNext !== RV)
      begin errors++; $display("FAIL boot got req=%b next=%h exp req=0 next=%h", imem_req, PCNext, RV); end
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      exp_pc = 32'(i * 4);
      checks++; if (PC !== exp_pc || imem_req !== 1'b1 || fetch_valid !== 1'b1)
        begin errors++; $display("FAIL seq_%0d got pc=%h req=%b fv=%b exp pc=%h 1 1", i, PC, imem_req, fetch_valid, exp_pc); end
      tick();
    end
  endtask

  task automatic test_wait();
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checks++; if (PC !== 32'h10 || fetch_valid !== 1'b0 || imem_req !== 1'b1)
        begin errors++; $display("FAIL wait_%0d got pc=%h fv=%b req=%b exp 10 0 1", i, PC, fetch_valid, imem_req); end
      tick();
    end
    idle(1'b1);
    tick();
    checks++; if (PC !== 32'h14) begin errors++; $display("FAIL wait_done got=%h exp=14", PC); end
  endtask

  task automatic test_stall_jump();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    checks++; if (fetch_valid !== 1'b0 || PCNext !== 32'h14)
      begin errors++; $display("FAIL stall_comb got fv=%b next=%h exp 0 14", fetch_valid, PCNext); end
    tick();
    checks++; if (PC !== 32'h14) begin errors++; $display("FAIL stall_hold got=%h exp=14", PC); end
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    tick();
    checks++; if (PC !== 32'h200) begin errors++; $display("FAIL stall_release got=%h exp=200", PC); end
  endtask

  task automatic test_priority();
    apply(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h41, 1'b0);
    tick();
    checks++; if (PC !== 32'h40) begin errors++; $display("FAIL prio_jump got=%h exp=40", PC); end
  endtask

  task automatic test_misalign_trap();
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
    tick();
    apply(1'b0, 1'b1, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0);
    checks++; if (PCNext !== 32'h20) begin errors++; $display("FAIL fault_next got=%h exp=20", PCNext); end
    tick();
    idle(1'b1);
    checks++; if (trap !== 1'b1 || PC !== 32'h20 || epc !== 32'h20 || imem_req !== 1'b0)
      begin errors++; $display("FAIL trap_cycle got trap=%b pc=%h epc=%h req=%b exp 1 20 20 0", trap, PC, epc, imem_req); end
    checks++; if (PCNext !== TV) begin errors++; $display("FAIL trap_next got=%h exp=%h", PCNext, TV); end
    tick();
    idle(1'b1);
    checks++; if (trap !== 1'b0 || PC !== TV)
      begin errors++; $display("FAIL trap_exit got trap=%b pc=%h exp 0 %h", trap, PC, TV); end
    tick();
    tick();
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checks++; if (PC !== 32'h24 || epc !== 32'h20)
      begin errors++; $display("FAIL trap_ret got pc=%h epc=%h exp 24 20", PC, epc); end
  endtask

  task automatic test_wrap();
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    idle(1'b1);
    tick();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_seq got=%h exp=0", PC); end
    // Fault from 0xFFFFFFFC so that epc+4 also wraps.
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    apply(1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 32'h0, 1'b0);
    tick();
    idle(1'b1);
    tick();
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checks++; if (PC !== 32'h0 || epc !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL wrap_ret got pc=%h epc=%h exp 0 fffffffc", PC, epc); end
  endtask

  task automatic test_async_reset();
    idle(1'b1); tick();
    idle(1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (PC !== RV || imem_req !== 1'b0 || epc !== 32'h0 || fetch_valid !== 1'b0)
      begin errors++; $display("FAIL async_rst got pc=%h req=%b epc=%h fv=%b exp %h 0 0 0", PC, imem_req, epc, fetch_valid, RV); end
    tick();
    rst = 1'b0;
    idle(1'b1);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_boot got req=%b exp=0", imem_req); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] bt, jt, got;
    for (int i = 0; i < 300; i++) begin
      bt = $urandom() & ~32'd3;
      jt = $urandom() & ~32'd2;
      if ($urandom_range(0, 7) == 0) bt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) jt[1]   = 1'b1;
      apply(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), bt, ($urandom_range(0, 4) == 0), jt,
            ($urandom_range(0, 9) == 0));
      checks++;
      if (PCNext !== e_next || fetch_valid !== e_valid || imem_req !== e_req ||
          trap !== e_trap || epc !== m_epc) begin
        errors++;
        $display("FAIL rand_%0d got next=%h fv=%b req=%b trap=%b epc=%h exp %h %b %b %b %h",
                 i, PCNext, fetch_valid, imem_req, trap, epc, e_next, e_valid, e_req, e_trap, m_epc);
      end
      exp_q.push_back(e_next);
      tick();
      got = exp_q.pop_front();
      checks++; if (PC !== got) begin errors++; $display("FAIL rand_pc_%0d got=%h exp=%h", i, PC, got); end
    end
  endtask

  initial begin
    stall = 0; imem_ready = 0; branch_taken = 0; branch_target = 0;
    jump = 0; jump_target = 0; trap_ret = 0;
    test_reset();
    test_sequential();
    test_wait();
    test_stall_jump();
    test_priority();
    test_misalign_trap();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
